// File: rtl/frame_buf_pkg.sv
// Shared types and constants for the triple-buffered LED frame store.
package frame_buf_pkg;

   // Bank role index: one of three banks.
   typedef logic [1:0] buf_idx_t;

   // Bank roles after reset: writer, ready and reader.
   localparam buf_idx_t WR_IDX_RST  = 2'd0;
   localparam buf_idx_t RDY_IDX_RST = 2'd1;
   localparam buf_idx_t RD_IDX_RST  = 2'd2;

   // Bytes held by one bank.
   function automatic int frame_depth(input int leds, input int bytes_per_led);
      return leds * bytes_per_led;
   endfunction

   // Byte address width for a bank, never narrower than one bit.
   function automatic int addr_bits(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/triple_frame_buffer_if.sv
// Writer/reader signal bundle for the frame store.
// Strobe semantics: i_wr_en, i_wr_commit and i_rd_frame_start are sampled on
// every rising edge and never back-pressured; o_rd_new and o_wr_oob are
// single-cycle pulses in the cycle after the causing edge; o_rd_data is valid
// one cycle after i_rd_addr is sampled; o_rd_valid and o_drop_count are levels.
interface triple_frame_buffer_if #(
   parameter int ADDR_WIDTH = 7,
   parameter int DROP_WIDTH = 8
);
   logic                  i_wr_en;
   logic [ADDR_WIDTH-1:0] i_wr_addr;
   logic [7:0]            i_wr_data;
   logic                  i_wr_commit;
   logic                  i_rd_frame_start;
   logic [ADDR_WIDTH-1:0] i_rd_addr;
   logic [7:0]            o_rd_data;
   logic                  o_rd_valid;
   logic                  o_rd_new;
   logic                  o_wr_oob;
   logic [DROP_WIDTH-1:0] o_drop_count;

   // Side that produces writes and frame starts.
   modport master (
      output i_wr_en, i_wr_addr, i_wr_data, i_wr_commit, i_rd_frame_start, i_rd_addr,
      input  o_rd_data, o_rd_valid, o_rd_new, o_wr_oob, o_drop_count
   );

   // The frame store itself.
   modport slave (
      input  i_wr_en, i_wr_addr, i_wr_data, i_wr_commit, i_rd_frame_start, i_rd_addr,
      output o_rd_data, o_rd_valid, o_rd_new, o_wr_oob, o_drop_count
   );
endinterface

// File: rtl/sdp_ram_bank.sv
// One frame bank: simple dual-port RAM, DEPTH x 8, registered read.
// Contents are not reset so the array maps onto block RAM.
module sdp_ram_bank #(
   parameter int DEPTH      = 90,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [7:0]            i_wdata,
   input  logic                  i_re,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [7:0]            o_rdata
);
   logic [7:0] r_mem [DEPTH];
   logic [7:0] r_rdata;

   // Write port; the caller only asserts i_we for in-range addresses.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Registered read port; held when the address is out of range.
   always_ff @(posedge i_clk) begin
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/triple_frame_buffer.sv
// Triple-buffered LED frame store. The writer fills one bank and commits it,
// the reader swaps in the newest committed bank only at its own frame start,
// so neither side stalls and no frame is ever torn.
module triple_frame_buffer
   import frame_buf_pkg::*;
#(
   parameter int LEDS          = 30,
   parameter int BYTES_PER_LED = 3,
   parameter int DEPTH         = frame_depth(LEDS, BYTES_PER_LED),
   parameter int ADDR_WIDTH    = addr_bits(DEPTH),
   parameter int DROP_WIDTH    = 8
) (
   input logic                  i_clk,
   input logic                  i_rst,
   triple_frame_buffer_if.slave bus
);
   // Bank size widened by one bit so DEPTH == 2**ADDR_WIDTH still compares.
   localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

   buf_idx_t              r_wr_idx;
   buf_idx_t              r_rdy_idx;
   buf_idx_t              r_rd_idx;
   logic                  r_fresh;
   buf_idx_t              r_rd_sel;
   logic                  r_rd_zero;
   logic                  r_rd_valid;
   logic                  r_rd_new;
   logic                  r_wr_oob;
   logic [DROP_WIDTH-1:0] r_drop_count;

   logic                  w_wr_in_range;
   logic                  w_rd_in_range;
   logic                  w_wr_ok;
   logic                  w_commit;
   logic                  w_start;
   logic [7:0]            w_bank_q [3];
   logic [7:0]            w_rd_data;

   assign w_wr_in_range = ({1'b0, bus.i_wr_addr} < DEPTH_EXT);
   assign w_rd_in_range = ({1'b0, bus.i_rd_addr} < DEPTH_EXT);
   assign w_wr_ok       = bus.i_wr_en && w_wr_in_range;
   assign w_commit      = bus.i_wr_commit;
   assign w_start       = bus.i_rd_frame_start;

   // Three identical banks; only the current writer bank sees the strobe.
   for (genvar g = 0; g < 3; g++) begin : g_bank
      sdp_ram_bank #(
         .DEPTH      (DEPTH),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_bank (
         .i_clk   (i_clk),
         .i_we    (w_wr_ok && (r_wr_idx == buf_idx_t'(g))),
         .i_waddr (bus.i_wr_addr),
         .i_wdata (bus.i_wr_data),
         .i_re    (w_rd_in_range),
         .i_raddr (bus.i_rd_addr),
         .o_rdata (w_bank_q[g])
      );
   end

   // Bank role rotation, fresh flag, pulses and the dropped-frame counter.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_idx     <= WR_IDX_RST;
         r_rdy_idx    <= RDY_IDX_RST;
         r_rd_idx     <= RD_IDX_RST;
         r_fresh      <= 1'b0;
         r_rd_sel     <= RD_IDX_RST;
         r_rd_zero    <= 1'b1;
         r_rd_valid   <= 1'b0;
         r_rd_new     <= 1'b0;
         r_wr_oob     <= 1'b0;
         r_drop_count <= '0;
      end else begin
         r_rd_new  <= 1'b0;
         r_wr_oob  <= bus.i_wr_en && !w_wr_in_range;
         // The read issued on this edge belongs to the bank the reader holds now.
         r_rd_sel  <= r_rd_idx;
         r_rd_zero <= !w_rd_in_range;

         if (w_commit && w_start) begin
            // Just-written frame goes straight to the reader; ready bank untouched.
            r_rd_idx   <= r_wr_idx;
            r_wr_idx   <= r_rd_idx;
            r_fresh    <= 1'b0;
            r_rd_valid <= 1'b1;
            r_rd_new   <= 1'b1;
         end else if (w_commit) begin
            r_wr_idx  <= r_rdy_idx;
            r_rdy_idx <= r_wr_idx;
            r_fresh   <= 1'b1;
         end else if (w_start && r_fresh) begin
            r_rd_idx   <= r_rdy_idx;
            r_rdy_idx  <= r_rd_idx;
            r_fresh    <= 1'b0;
            r_rd_valid <= 1'b1;
            r_rd_new   <= 1'b1;
         end

         // Any commit while the ready frame is still unread discards that frame.
         if (w_commit && r_fresh && (r_drop_count != '1)) begin
            r_drop_count <= r_drop_count + 1'b1;
         end
      end
   end

   // Output mux over the bank read registers; out-of-range reads return zero.
   always_comb begin
      w_rd_data = 8'h00;
      if (!r_rd_zero) begin
         case (r_rd_sel)
            2'd0:    w_rd_data = w_bank_q[0];
            2'd1:    w_rd_data = w_bank_q[1];
            2'd2:    w_rd_data = w_bank_q[2];
            default: w_rd_data = 8'h00;
         endcase
      end
   end

   assign bus.o_rd_data    = w_rd_data;
   assign bus.o_rd_valid   = r_rd_valid;
   assign bus.o_rd_new     = r_rd_new;
   assign bus.o_wr_oob     = r_wr_oob;
   assign bus.o_drop_count = r_drop_count;
endmodule

// File: tb/tb_triple_frame_buffer.sv
// Bench for triple_frame_buffer: an RGB (90-byte) and an RGBW (120-byte)
// instance share one stimulus stream and are each tracked by a frame-level model.
module tb_triple_frame_buffer;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- shared stimulus ----------------
   logic       wr_en     = 1'b0;
   logic [6:0] wr_addr   = '0;
   logic [7:0] wr_data   = '0;
   logic       wr_commit = 1'b0;
   logic       rd_start  = 1'b0;
   logic [6:0] rd_addr   = '0;

   triple_frame_buffer_if #(.ADDR_WIDTH(7), .DROP_WIDTH(8)) bus3 ();
   triple_frame_buffer_if #(.ADDR_WIDTH(7), .DROP_WIDTH(8)) bus4 ();

   assign bus3.i_wr_en = wr_en;           assign bus4.i_wr_en = wr_en;
   assign bus3.i_wr_addr = wr_addr;       assign bus4.i_wr_addr = wr_addr;
   assign bus3.i_wr_data = wr_data;       assign bus4.i_wr_data = wr_data;
   assign bus3.i_wr_commit = wr_commit;   assign bus4.i_wr_commit = wr_commit;
   assign bus3.i_rd_frame_start = rd_start; assign bus4.i_rd_frame_start = rd_start;
   assign bus3.i_rd_addr = rd_addr;       assign bus4.i_rd_addr = rd_addr;

   triple_frame_buffer #(.LEDS(30), .BYTES_PER_LED(3), .DROP_WIDTH(8)) dut3 (
      .i_clk (clk), .i_rst (rst), .bus (bus3)
   );
   triple_frame_buffer #(.LEDS(30), .BYTES_PER_LED(4), .DROP_WIDTH(8)) dut4 (
      .i_clk (clk), .i_rst (rst), .bus (bus4)
   );

   logic [7:0] a_rd_data [2];
   logic       a_rd_valid[2];
   logic       a_rd_new  [2];
   logic       a_wr_oob  [2];
   logic [7:0] a_drop    [2];
   assign a_rd_data[0] = bus3.o_rd_data;  assign a_rd_data[1] = bus4.o_rd_data;
   assign a_rd_valid[0] = bus3.o_rd_valid; assign a_rd_valid[1] = bus4.o_rd_valid;
   assign a_rd_new[0] = bus3.o_rd_new;    assign a_rd_new[1] = bus4.o_rd_new;
   assign a_wr_oob[0] = bus3.o_wr_oob;    assign a_wr_oob[1] = bus4.o_wr_oob;
   assign a_drop[0] = bus3.o_drop_count;  assign a_drop[1] = bus4.o_drop_count;

   // ---------------- scoreboard counters ----------------
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   // Each role (writer / ready / reader) holds a whole frame image; committing
   // and acquiring move images between roles. k[] marks bytes written since reset.
   typedef struct {
      logic [7:0] d [128];
      bit         k [128];
   } frame_t;

   int     depth_m [2] = '{90, 120};
   frame_t wf [2];
   frame_t yf [2];
   frame_t rf [2];
   frame_t tmp_f;
   bit     m_fresh [2];
   bit     e_valid [2];
   bit     e_new   [2];
   bit     e_oob   [2];
   int     e_drop  [2];
   logic [7:0] e_rd [2];
   bit     e_rd_k  [2];

   always @(posedge clk or posedge rst) begin
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            for (int i = 0; i < 128; i++) begin
               wf[m].k[i] = 1'b0; yf[m].k[i] = 1'b0; rf[m].k[i] = 1'b0;
            end
            m_fresh[m] = 0; e_valid[m] = 0; e_new[m] = 0; e_oob[m] = 0;
            e_drop[m] = 0; e_rd[m] = 8'h00; e_rd_k[m] = 1;
         end else begin
            if (int'(rd_addr) >= depth_m[m]) begin
               e_rd[m] = 8'h00; e_rd_k[m] = 1;
            end else begin
               e_rd[m] = rf[m].d[rd_addr]; e_rd_k[m] = rf[m].k[rd_addr];
            end
            e_new[m] = 0;
            e_oob[m] = wr_en && (int'(wr_addr) >= depth_m[m]);
            if (wr_en && (int'(wr_addr) < depth_m[m])) begin
               wf[m].d[wr_addr] = wr_data; wf[m].k[wr_addr] = 1'b1;
            end
            if (wr_commit && m_fresh[m] && e_drop[m] < 255) e_drop[m]++;
            if (wr_commit && rd_start) begin
               tmp_f = rf[m]; rf[m] = wf[m]; wf[m] = tmp_f;
               m_fresh[m] = 0; e_valid[m] = 1; e_new[m] = 1;
            end else if (wr_commit) begin
               tmp_f = wf[m]; wf[m] = yf[m]; yf[m] = tmp_f;
               m_fresh[m] = 1;
            end else if (rd_start && m_fresh[m]) begin
               tmp_f = rf[m]; rf[m] = yf[m]; yf[m] = tmp_f;
               m_fresh[m] = 0; e_valid[m] = 1; e_new[m] = 1;
            end
         end
      end
   end

   // Every-cycle compare on the falling edge.
   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("rd_valid[%0d]", m), 32'(a_rd_valid[m]), 32'(e_valid[m]));
         chk($sformatf("rd_new[%0d]", m), 32'(a_rd_new[m]), 32'(e_new[m]));
         chk($sformatf("wr_oob[%0d]", m), 32'(a_wr_oob[m]), 32'(e_oob[m]));
         chk($sformatf("drop_count[%0d]", m), 32'(a_drop[m]), 32'(e_drop[m]));
         if (e_rd_k[m]) chk($sformatf("rd_data[%0d]", m), 32'(a_rd_data[m]), 32'(e_rd[m]));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
   endtask

   // kind 0: ramp with byte 0 = 0x11 and byte 89 = 0x5A; kind 1: base + i.
   task automatic write_frame(input int n, input int kind, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         wr_en   = 1'b1;
         wr_addr = 7'(i);
         wr_data = (kind == 0) ? 8'(8'h11 + (i * 73) / 89) : 8'(base + 8'(i));
         tick();
      end
      wr_en = 1'b0;
   endtask

   task automatic commit();
      wr_commit = 1'b1; tick(); wr_commit = 1'b0;
   endtask

   task automatic frame_start();
      rd_start = 1'b1; tick(); rd_start = 1'b0;
   endtask

   task automatic read(input int a, output logic [7:0] d3, output logic [7:0] d4);
      rd_addr = 7'(a);
      tick();
      d3 = bus3.o_rd_data;
      d4 = bus4.o_rd_data;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed + random sequence ----------------
   logic [7:0] d3, d4;
   initial begin
      do_reset();
      chk("rst_rd_valid", 32'(bus3.o_rd_valid), 32'd0);
      chk("rst_rd_data", 32'(bus3.o_rd_data), 32'd0);
      chk("rst_wr_idx", 32'(dut3.r_wr_idx), 32'd0);
      chk("rst_rdy_idx", 32'(dut3.r_rdy_idx), 32'd1);
      chk("rst_rd_idx", 32'(dut3.r_rd_idx), 32'd2);

      // First frame: ramp, commit, acquire.
      write_frame(90, 0, 8'h00);
      commit();
      frame_start();
      chk("first_rd_new", 32'(bus3.o_rd_new), 32'd1);
      chk("first_rd_valid", 32'(bus3.o_rd_valid), 32'd1);
      read(0, d3, d4);
      chk("first_addr0", 32'(d3), 32'h11);
      read(89, d3, d4);
      chk("first_addr89", 32'(d3), 32'h5A);

      // Three unread commits, then one frame start.
      do_reset();
      write_frame(90, 1, 8'h20); commit();
      write_frame(90, 1, 8'h60); commit();
      write_frame(90, 1, 8'hA0); commit();
      chk("three_commit_drop", 32'(bus3.o_drop_count), 32'd2);
      frame_start();
      read(0, d3, d4);
      chk("third_frame_addr0", 32'(d3), 32'hA0);
      read(5, d3, d4);
      chk("third_frame_addr5", 32'(d3), 32'hA5);

      // Commit and frame start together while a ready frame is unread.
      write_frame(90, 1, 8'h30); commit();
      write_frame(90, 1, 8'hC0);
      wr_commit = 1'b1; rd_start = 1'b1; tick(); wr_commit = 1'b0; rd_start = 1'b0;
      chk("bypass_rd_new", 32'(bus3.o_rd_new), 32'd1);
      chk("bypass_drop", 32'(bus3.o_drop_count), 32'd3);
      chk("bypass_fresh", 32'(dut3.r_fresh), 32'd0);
      read(0, d3, d4);
      chk("bypass_addr0", 32'(d3), 32'hC0);

      // Frame start with nothing fresh replays the current bank.
      frame_start();
      chk("replay_no_new", 32'(bus3.o_rd_new), 32'd0);
      read(7, d3, d4);
      chk("replay_addr7", 32'(d3), 32'hC7);

      // Out-of-range write and read on the 90-byte instance.
      wr_en = 1'b1; wr_addr = 7'd90; wr_data = 8'hEE; tick(); wr_en = 1'b0;
      chk("oob_pulse", 32'(bus3.o_wr_oob), 32'd1);
      tick();
      chk("oob_pulse_end", 32'(bus3.o_wr_oob), 32'd0);
      read(95, d3, d4);
      chk("oob_read_zero", 32'(d3), 32'd0);

      // Random traffic with occasional resets.
      for (int c = 0; c < 800; c++) begin
         rst       = ($urandom_range(0, 199) == 0);
         wr_en     = 1'($urandom_range(0, 1));
         wr_addr   = 7'($urandom_range(0, 127));
         wr_data   = 8'($urandom);
         wr_commit = ($urandom_range(0, 7) == 0);
         rd_start  = ($urandom_range(0, 7) == 0);
         rd_addr   = 7'($urandom_range(0, 127));
         tick();
      end
      rst = 1'b0; wr_en = 1'b0; wr_commit = 1'b0; rd_start = 1'b0;
      tick();

      // RGBW instance: reset mid-write, then a full 120-byte frame.
      write_frame(60, 1, 8'h40); commit(); commit(); frame_start(); commit();
      write_frame(50, 1, 8'h50);
      rst = 1'b1;
      #1;
      chk("midrst_valid", 32'(bus4.o_rd_valid), 32'd0);
      chk("midrst_drop", 32'(bus4.o_drop_count), 32'd0);
      chk("midrst_rd_data", 32'(bus4.o_rd_data), 32'd0);
      chk("midrst_wr_idx", 32'(dut4.r_wr_idx), 32'd0);
      chk("midrst_rdy_idx", 32'(dut4.r_rdy_idx), 32'd1);
      chk("midrst_rd_idx", 32'(dut4.r_rd_idx), 32'd2);
      tick(); rst = 1'b0;
      write_frame(120, 1, 8'h01);
      commit();
      frame_start();
      for (int a = 0; a < 120; a++) read(a, d3, d4);
      read(119, d3, d4);
      chk("rgbw_addr119", 32'(d4), 32'h78);

      // Saturation: 300 back-to-back commits with no frame start.
      do_reset();
      wr_commit = 1'b1;
      for (int c = 0; c < 300; c++) tick();
      wr_commit = 1'b0;
      tick();
      chk("sat_drop3", 32'(bus3.o_drop_count), 32'd255);
      chk("sat_drop4", 32'(bus4.o_drop_count), 32'd255);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
